// File: rtl/iomem_arb_pkg.sv
// Shared definitions for the iomem round-robin arbiter.
//   arb_state_e              : arbiter FSM states (IDLE, BUSY, GAP)
//   IOMEM_ARB_TIMEOUT_RDATA  : read data returned to a master whose access timed out
//   IOMEM_ARB_MAX_REQ        : largest supported number of masters
package iomem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_e;

  localparam logic [31:0] IOMEM_ARB_TIMEOUT_RDATA = 32'hDEAD_BEEF;
  localparam int          IOMEM_ARB_MAX_REQ       = 8;

endpackage

// File: rtl/iomem_rr_picker.sv
// Combinational round-robin picker.
// Finds the first set bit of req starting at position ptr and wrapping from
// NUM_REQ-1 back to 0.
// Ports:
//   req  in  NUM_REQ          request vector
//   ptr  in  $clog2(NUM_REQ)  highest-priority position
//   any  out 1                at least one request is set
//   idx  out $clog2(NUM_REQ)  index of the chosen request (0 when none)
module iomem_rr_picker #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic                       any,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  // Walk offsets from farthest to nearest so the nearest requester after
  // ptr is the last (and therefore winning) assignment.
  always_comb begin
    int pos;
    any = |req;
    idx = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      pos = int'(ptr) + k;
      if (pos >= NUM_REQ) pos = pos - NUM_REQ;
      if (req[pos]) idx = pos[IW-1:0];
    end
  end

endmodule

// File: rtl/iomem_rr_arbiter.sv
// Round-robin arbiter sharing one picosoc iomem slave port among NUM_REQ
// iomem masters. Transactions are serialised; each slave response goes only
// to the master that issued it.
// Optional build macro: IOMEM_ARB_TIMEOUT_EN -- forces completion (with
// IOMEM_ARB_TIMEOUT_RDATA) after TIMEOUT_CYCLES BUSY cycles without s_ready
// and sets the sticky timeout_flag. Undefined: BUSY waits indefinitely.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   m_valid / m_ready     per-master request / one-cycle completion pulse
//   m_wstrb/m_addr/m_wdata per-master request fields, master i at slice i
//   m_rdata               shared read data, non-zero only with an m_ready pulse
//   s_valid/s_ready       slave request / slave completion pulse
//   s_wstrb/s_addr/s_wdata forwarded fields of the granted master
//   s_rdata               slave read data
//   grant_id              index of current/last granted master
//   timeout_flag          sticky timeout indicator (0 without the timeout build)
module iomem_rr_arbiter
  import iomem_arb_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         m_valid,
  output logic [NUM_REQ-1:0]         m_ready,
  input  logic [4*NUM_REQ-1:0]       m_wstrb,
  input  logic [32*NUM_REQ-1:0]      m_addr,
  input  logic [32*NUM_REQ-1:0]      m_wdata,
  output logic [31:0]                m_rdata,
  output logic                       s_valid,
  input  logic                       s_ready,
  output logic [3:0]                 s_wstrb,
  output logic [31:0]                s_addr,
  output logic [31:0]                s_wdata,
  input  logic [31:0]                s_rdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       timeout_flag
);

  localparam int IW = $clog2(NUM_REQ);

  arb_state_e    state_q, state_d;
  logic [IW-1:0] rr_ptr_q, rr_ptr_d;
  logic [IW-1:0] grant_q, grant_d;

  logic          pick_any;
  logic [IW-1:0] pick_idx;
  logic          busy;
  logic          gnt_valid;
  logic          timeout_hit;
  logic          done;

`ifdef IOMEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flag_q, flag_d;
`endif

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    if (int'(p) == NUM_REQ - 1) return '0;
    return p + 1'b1;
  endfunction

  iomem_rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req (m_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  assign grant_id = grant_q;

  // Request fields always follow the granted master, even outside BUSY.
  assign s_wstrb = m_wstrb[4*int'(grant_q) +: 4];
  assign s_addr  = m_addr[32*int'(grant_q) +: 32];
  assign s_wdata = m_wdata[32*int'(grant_q) +: 32];

  always_comb begin
    busy        = (state_q == ST_BUSY);
    gnt_valid   = m_valid[grant_q];
    timeout_hit = 1'b0;
`ifdef IOMEM_ARB_TIMEOUT_EN
    // s_ready on the limit cycle is a normal completion, not a timeout.
    timeout_hit = busy && gnt_valid && !s_ready && (cnt_q == CNT_MAX);
`endif
    // A master that withdrew its request is never completed.
    done    = busy && gnt_valid && (s_ready || timeout_hit);
    s_valid = busy && gnt_valid;
    m_ready = '0;
    m_rdata = '0;
    if (done) begin
      m_ready[grant_q] = 1'b1;
      m_rdata          = timeout_hit ? IOMEM_ARB_TIMEOUT_RDATA : s_rdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
`ifdef IOMEM_ARB_TIMEOUT_EN
    cnt_d    = cnt_q;
    flag_d   = flag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          state_d = ST_BUSY;
`ifdef IOMEM_ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_BUSY: begin
        if (!gnt_valid) begin
          state_d = ST_IDLE;
        end else if (done) begin
          rr_ptr_d = ptr_inc(grant_q);
          state_d  = ST_GAP;
`ifdef IOMEM_ARB_TIMEOUT_EN
          if (timeout_hit) flag_d = 1'b1;
`endif
        end else begin
`ifdef IOMEM_ARB_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      ST_GAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
`ifdef IOMEM_ARB_TIMEOUT_EN
      cnt_q    <= '0;
      flag_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
`ifdef IOMEM_ARB_TIMEOUT_EN
      cnt_q    <= cnt_d;
      flag_q   <= flag_d;
`endif
    end
  end

`ifdef IOMEM_ARB_TIMEOUT_EN
  assign timeout_flag = flag_q;
`else
  assign timeout_flag = 1'b0;
`endif

endmodule

// File: tb/tb_iomem_rr_arbiter.sv
module tb_iomem_rr_arbiter;

  localparam int N = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [N-1:0]  m_valid = '0;
  logic [N-1:0]  m_ready;
  logic [4*N-1:0]  m_wstrb = '0;
  logic [32*N-1:0] m_addr = '0;
  logic [32*N-1:0] m_wdata = '0;
  logic [31:0]   m_rdata;
  logic          s_valid;
  logic          s_ready = 1'b0;
  logic [3:0]    s_wstrb;
  logic [31:0]   s_addr;
  logic [31:0]   s_wdata;
  logic [31:0]   s_rdata = '0;
  logic [0:0]    grant_id;
  logic          timeout_flag;

  int n_checks = 0;
  int n_fail   = 0;

  iomem_rr_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .m_valid(m_valid), .m_ready(m_ready),
    .m_wstrb(m_wstrb), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_wstrb(s_wstrb), .s_addr(s_addr), .s_wdata(s_wdata), .s_rdata(s_rdata),
    .grant_id(grant_id), .timeout_flag(timeout_flag)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; m_valid = '0; s_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL reset_s_valid got %b exp 0", s_valid); end
    n_checks++; if (m_ready !== 2'b00) begin n_fail++; $display("FAIL reset_m_ready got %b exp 00", m_ready); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL reset_grant got %0d exp 0", grant_id); end
    n_checks++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL reset_flag got %b exp 0", timeout_flag); end
    n_checks++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h exp 0", m_rdata); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_write();
    do_reset();
    m_wstrb[3:0] = 4'hF; m_addr[31:0] = 32'h0300_0000; m_wdata[31:0] = 32'h3;
    m_valid = 2'b01;
    @(negedge clk);
    n_checks++; if (s_valid !== 1'b0) begin n_fail++; $display("FAIL wr_arb_latency s_valid got %b exp 0", s_valid); end
    tick();
    @(negedge clk);
    n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL wr_s_valid got %b exp 1", s_valid); end
    n_checks++; if ({s_wstrb, s_addr, s_wdata} !== {4'hF, 32'h0300_0000, 32'h3})
      begin n_fail++; $display("FAIL wr_fwd got %h/%h/%h exp f/03000000/00000003", s_wstrb, s_addr, s_wdata); end
    n_checks++; if (m_ready !== 2'b00) begin n_fail++; $display("FAIL wr_early_ready got %b exp 00", m_ready); end
    tick();
    s_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_ready !== 2'b01) begin n_fail++; $display("FAIL wr_m_ready got %b exp 01", m_ready); end
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL wr_grant got %0d exp 0", grant_id); end
    tick();
    s_ready = 1'b0; m_valid = 2'b00;
    @(negedge clk);
    n_checks++; if ({s_valid, m_ready} !== 3'b000) begin n_fail++; $display("FAIL wr_gap got %b exp 000", {s_valid, m_ready}); end
    tick();
  endtask

  task automatic test_alternate();
    logic [0:0] exp_g;
    int n;
    do_reset();
    m_addr = {32'h0300_0104, 32'h0300_0100};
    m_wdata = {32'h11, 32'h10};
    m_wstrb = 8'hFF;
    m_valid = 2'b11;
    for (int t = 0; t < 4; t++) begin
      exp_g = 1'(t % 2);
      n = 0;
      while (!s_valid && n < 8) begin tick(); n++; end
      n_checks++; if (n >= 8) begin n_fail++; $display("FAIL alt_timeout txn %0d no s_valid", t); end
      @(negedge clk);
      n_checks++; if (grant_id !== exp_g) begin n_fail++; $display("FAIL alt_grant txn %0d got %0d exp %0d", t, grant_id, exp_g); end
      n_checks++; if (s_addr !== (exp_g ? 32'h0300_0104 : 32'h0300_0100))
        begin n_fail++; $display("FAIL alt_addr txn %0d got %h", t, s_addr); end
      tick();
      s_ready = 1'b1;
      @(negedge clk);
      n_checks++; if (m_ready !== (2'b01 << exp_g)) begin n_fail++; $display("FAIL alt_ready txn %0d got %b exp %b", t, m_ready, 2'b01 << exp_g); end
      tick();
      s_ready = 1'b0;
      @(negedge clk);
      n_checks++; if (m_ready !== 2'b00) begin n_fail++; $display("FAIL alt_gap txn %0d got %b exp 00", t, m_ready); end
    end
    m_valid = 2'b00;
    tick();
  endtask

  task automatic test_read();
    do_reset();
    m_wstrb[7:4] = 4'h0; m_addr[63:32] = 32'h0300_0008;
    m_valid = 2'b10;
    tick();
    @(negedge clk);
    n_checks++; if (grant_id !== 1'b1) begin n_fail++; $display("FAIL rd_grant got %0d exp 1", grant_id); end
    n_checks++; if (s_wstrb !== 4'h0) begin n_fail++; $display("FAIL rd_wstrb got %h exp 0", s_wstrb); end
    s_rdata = 32'h0000_0005;
    @(negedge clk);
    n_checks++; if (m_rdata !== 32'h0) begin n_fail++; $display("FAIL rd_rdata_early got %h exp 0", m_rdata); end
    tick();
    s_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_ready !== 2'b10) begin n_fail++; $display("FAIL rd_ready got %b exp 10", m_ready); end
    n_checks++; if (m_rdata !== 32'h5) begin n_fail++; $display("FAIL rd_rdata got %h exp 5", m_rdata); end
    tick();
    // s_ready left high through GAP must be ignored.
    @(negedge clk);
    n_checks++; if ({m_ready, m_rdata} !== 34'h0) begin n_fail++; $display("FAIL rd_gap_ignore got %b/%h exp 00/0", m_ready, m_rdata); end
    s_ready = 1'b0; m_valid = 2'b00; s_rdata = '0;
    tick();
  endtask

  task automatic test_abort();
    do_reset();
    m_valid = 2'b01;
    tick();
    @(negedge clk);
    n_checks++; if (s_valid !== 1'b1) begin n_fail++; $display("FAIL ab_busy got %b exp 1", s_valid); end
    tick();
    m_valid = 2'b00;
    tick();
    @(negedge clk);
    n_checks++; if ({s_valid, m_ready} !== 3'b000) begin n_fail++; $display("FAIL ab_drop got %b exp 000", {s_valid, m_ready}); end
    m_valid = 2'b11;
    tick();
    @(negedge clk);
    n_checks++; if (grant_id !== 1'b0) begin n_fail++; $display("FAIL ab_ptr_kept got %0d exp 0", grant_id); end
    s_ready = 1'b1;
    tick();
    s_ready = 1'b0; m_valid = 2'b00;
    tick();
  endtask

  task automatic test_reset_busy();
    do_reset();
    m_valid = 2'b10;
    tick();
    @(negedge clk);
    n_checks++; if ({s_valid, grant_id} !== 2'b11) begin n_fail++; $display("FAIL rb_busy got %b exp 11", {s_valid, grant_id}); end
    reset = 1'b1;
    tick();
    @(negedge clk);
    n_checks++; if ({s_valid, m_ready, grant_id} !== 4'b0000) begin n_fail++; $display("FAIL rb_cleared got %b exp 0000", {s_valid, m_ready, grant_id}); end
    reset = 1'b0; m_valid = 2'b00; s_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_ready !== 2'b00) begin n_fail++; $display("FAIL rb_late_ready got %b exp 00", m_ready); end
    tick();
    s_ready = 1'b0;
  endtask

`ifdef IOMEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    m_valid = 2'b01;
    tick();
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      n_checks++; if (m_ready !== 2'b00) begin n_fail++; $display("FAIL to_early busy cycle %0d got %b exp 00", i, m_ready); end
      tick();
    end
    @(negedge clk);
    n_checks++; if (m_ready !== 2'b01) begin n_fail++; $display("FAIL to_ready got %b exp 01", m_ready); end
    n_checks++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL to_rdata got %h exp deadbeef", m_rdata); end
    tick();
    m_valid = 2'b00;
    tick(); tick();
    @(negedge clk);
    n_checks++; if (timeout_flag !== 1'b1) begin n_fail++; $display("FAIL to_flag_sticky got %b exp 1", timeout_flag); end
    do_reset();
    @(negedge clk);
    n_checks++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL to_flag_reset got %b exp 0", timeout_flag); end
    // s_ready on the limit cycle completes normally.
    s_rdata = 32'h0000_0077;
    m_valid = 2'b01;
    tick();
    tick(); tick(); tick(); tick();
    s_ready = 1'b1;
    @(negedge clk);
    n_checks++; if ({m_ready, m_rdata} !== {2'b01, 32'h77}) begin n_fail++; $display("FAIL to_race got %b/%h exp 01/77", m_ready, m_rdata); end
    tick();
    s_ready = 1'b0; m_valid = 2'b00;
    @(negedge clk);
    n_checks++; if (timeout_flag !== 1'b0) begin n_fail++; $display("FAIL to_race_flag got %b exp 0", timeout_flag); end
    tick();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    m_valid = 2'b01;
    tick();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++; if ({m_ready, s_valid, timeout_flag} !== 4'b0010)
        begin n_fail++; $display("FAIL nto_wait cycle %0d got %b exp 0010", i, {m_ready, s_valid, timeout_flag}); end
      tick();
    end
    s_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (m_ready !== 2'b01) begin n_fail++; $display("FAIL nto_ready got %b exp 01", m_ready); end
    tick();
    s_ready = 1'b0; m_valid = 2'b00;
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_alternate();
    test_read();
    test_abort();
    test_reset_busy();
`ifdef IOMEM_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  always @(negedge clk) begin
    if (!reset && m_ready == 2'b11) begin
      n_fail++;
      $display("FAIL onehot m_ready got %b exp at most one bit", m_ready);
    end
  end

endmodule
